// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, RAM defaults and burst-counter sizing for the RAM port arbiter
package ram_arb_pkg;
  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;
  localparam int AW_DEF    = 17;
  localparam int DW_DEF    = 8;
  localparam int RAM_DEPTH = 76800;
  localparam int PERF_W    = 16;
  function automatic int bcnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction
endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot selector, lowest distance from the pointer wins
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o
);
  int w_best;
  int w_off;
  // pick the requester closest to the pointer, searching upward with wrap
  always_comb begin
    pick_o = '0;
    w_best = N;
    w_off  = 0;
    for (int i = 0; i < N; i++) begin
      w_off = (i - int'(ptr_i) + N) % N;
      if (req_i[i] && w_off < w_best) begin
        w_best    = w_off;
        pick_o    = '0;
        pick_o[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: burst-locked round-robin sharing of one single-port RAM; RAM_ARB_PERF_EN adds per-requester access counters
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ-1:0]    last_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic               ram_en_o,
  output logic               ram_we_o,
  output logic [AW-1:0]      ram_addr_o,
  output logic [DW-1:0]      ram_wdata_o,
  input  logic [DW-1:0]      ram_rdata_i
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [NREQ*PERF_W-1:0] perf_gnt_cnt_o
`endif
);
  localparam int PW = $clog2(NREQ);
  localparam int BW = bcnt_width(MAX_BURST);
  arb_state_e       r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_rvalid;
  logic [PW-1:0]    r_ptr;
  logic [BW-1:0]    r_bcnt;
  logic [NREQ-1:0]  w_pick;
  logic [PW-1:0]    w_gidx;
  logic             w_acc;
  logic             w_we;
  logic             w_rel;
  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req_i (req_i),
    .ptr_i (r_ptr),
    .pick_o(w_pick)
  );
  assign w_acc       = |(r_gnt & req_i);
  assign w_we        = |(r_gnt & we_i);
  assign w_rel       = !w_acc || |(r_gnt & last_i) || r_bcnt == BW'(MAX_BURST - 1);
  assign ram_en_o    = w_acc;
  assign ram_we_o    = w_acc & w_we;
  assign gnt_o       = r_gnt;
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = ram_rdata_i;
  // owner index and RAM address/data mux, zero unless an access is accepted
  always_comb begin
    w_gidx      = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) w_gidx = PW'(i);
      if (r_gnt[i] && req_i[i]) begin
        ram_addr_o  = addr_i[i*AW +: AW];
        ram_wdata_o = wdata_i[i*DW +: DW];
      end
    end
  end
  // grant FSM: pick in IDLE, hold in OWN until last, burst limit or dropped request
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_bcnt  <= '0;
    end else if (r_state == IDLE) begin
      if (|req_i) begin
        r_gnt   <= w_pick;
        r_state <= OWN;
      end
    end else if (w_rel) begin
      r_gnt   <= '0;
      r_ptr   <= PW'((int'(w_gidx) + 1) % NREQ);
      r_bcnt  <= '0;
      r_state <= IDLE;
    end else
      r_bcnt <= r_bcnt + BW'(1);
  // read-return strobe to the requester whose read was accepted last cycle
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) r_rvalid <= '0;
    else r_rvalid <= (w_acc && !w_we) ? r_gnt : '0;
`ifdef RAM_ARB_PERF_EN
  logic [NREQ-1:0][PERF_W-1:0] r_perf;
  assign perf_gnt_cnt_o = r_perf;
  // saturating count of accepted accesses per requester
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) r_perf <= '0;
    else
      for (int i = 0; i < NREQ; i++)
        if (r_gnt[i] && req_i[i] && !(&r_perf[i])) r_perf[i] <= r_perf[i] + PERF_W'(1);
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: random burst traffic against a spec-level arbitration model with a RAM-op and read-return scoreboard
module tb_ram_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int MB = 16;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic last;} acc_t;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} op_t;
  typedef struct {int due; logic [N-1:0] oh; logic [DW-1:0] data;} rd_t;
  logic clk = 1'b0;
  logic rstn_i;
  logic [N-1:0] req_i, we_i, last_i, gnt_o, rvalid_o;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [DW-1:0] rdata_o, ram_wdata_o, ram_rdata;
  logic ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
`ifdef RAM_ARB_PERF_EN
  logic [N*16-1:0] perf_gnt_cnt_o;
`endif
  acc_t pend [N][$];
  op_t  op_q [$];
  rd_t  rd_q [$];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] ram_mem [64];
  logic [N-1:0] m_gnt;
  int m_ptr, m_cnt, cyc, checks, passed;
  int m_perf [N];
  bit mon_en, bubbles, rd_seen;
  ram_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i), .last_i(last_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata)
`ifdef RAM_ARB_PERF_EN
    , .perf_gnt_cnt_o(perf_gnt_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 5) ? 8'hA5 : 8'(a * 29 + 7);
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  // one-cycle behavioural single-port RAM with 1-cycle read latency
  initial begin
    ram_rdata = '0;
    for (int i = 0; i < 64; i++) ram_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (ram_en_o) begin
        if (ram_we_o) ram_mem[ram_addr_o[5:0]] = ram_wdata_o;
        else ram_rdata = ram_mem[ram_addr_o[5:0]];
      end
    end
  end
  task automatic gen(input int r, input int nb);
    acc_t a;
    int len;
    for (int b = 0; b < nb; b++) begin
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        a.we = 1'($urandom_range(0, 1));
        a.addr = AW'($urandom_range(0, 63));
        a.wdata = DW'($urandom);
        a.last = (k == len - 1);
        pend[r].push_back(a);
      end
    end
  endtask
  task automatic put(input int r, input logic we, input int addr, input logic [DW-1:0] d);
    acc_t a;
    a.we = we; a.addr = AW'(addr); a.wdata = d; a.last = 1'b1;
    pend[r].push_back(a);
  endtask
  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += pend[i].size();
    return s;
  endfunction
  // drive one cycle of requester traffic and advance the reference model
  task automatic step();
    logic [N-1:0] nxt;
    acc_t a;
    int g, idx;
    bit acc;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() > 0 && !(bubbles && $urandom_range(0, 15) == 0)) begin
        req_i[i] = 1'b1;
        we_i[i] = pend[i][0].we;
        last_i[i] = pend[i][0].last;
        addr_i[i*AW +: AW] = pend[i][0].addr;
        wdata_i[i*DW +: DW] = pend[i][0].wdata;
      end else begin
        req_i[i] = 1'b0;
        we_i[i] = 1'($urandom_range(0, 1));
        last_i[i] = 1'b0;
      end
    end
    #1;
    chk("gnt", gnt_o, m_gnt);
    nxt = m_gnt;
    if (m_gnt == '0) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (m_ptr + k) % N;
        if (((req_i >> idx) & 1) != 0) nxt = N'(1) << idx;
      end
      m_cnt = 0;
    end else begin
      g = 0;
      for (int i = 0; i < N; i++) if (((m_gnt >> i) & 1) != 0) g = i;
      acc = ((req_i >> g) & 1) != 0;
      a.last = 1'b0;
      if (acc) begin
        a = pend[g].pop_front();
        m_cnt++;
        m_perf[g]++;
        op_q.push_back('{a.we, a.addr, a.wdata});
        if (!a.we) begin
          rd_q.push_back('{cyc + 1, m_gnt, ref_mem[a.addr[5:0]]});
          rd_seen = 1'b1;
        end else ref_mem[a.addr[5:0]] = a.wdata;
      end
      if (!acc || a.last || m_cnt == MB) begin
        nxt = '0;
        m_ptr = (g + 1) % N;
        m_cnt = 0;
      end
    end
    m_gnt = nxt;
  endtask
  task automatic drain();
    int n = 0;
    while (pending() > 0 && n < 20000) begin
      step();
      n++;
    end
    chk("drain", 64'(pending()), 64'd0);
    repeat (3) step();
  endtask
  op_t mo;
  rd_t mr;
  bit  m_exp_en;
  // scoreboard monitor: every RAM access and read return must match the model's queues
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        m_exp_en = op_q.size() > 0;
        chk("ram_en", 64'(ram_en_o), 64'(m_exp_en));
        if (m_exp_en) begin
          mo = op_q.pop_front();
          if (ram_en_o) chk("ram_op", {ram_we_o, ram_addr_o, ram_wdata_o}, {mo.we, mo.addr, mo.wdata});
        end else chk("ram_idle", {ram_we_o, ram_addr_o, ram_wdata_o}, 64'd0);
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
          mr = rd_q.pop_front();
          chk("rvalid", rvalid_o, mr.oh);
          chk("rdata", rdata_o, mr.data);
        end else chk("rvalid_idle", rvalid_o, 64'd0);
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n;
    rstn_i = 1'b0; req_i = '0; we_i = '0; last_i = '0; addr_i = '0; wdata_i = '0;
    mon_en = 1'b0; bubbles = 1'b1; rd_seen = 1'b0;
    cyc = 0; checks = 0; passed = 0; m_gnt = '0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < N; i++) m_perf[i] = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", gnt_o, 64'd0);
    chk("rst_rvalid", rvalid_o, 64'd0);
    chk("rst_ram_en", 64'(ram_en_o), 64'd0);
    @(negedge clk);
    rstn_i = 1'b1;
    mon_en = 1'b1;
    put(0, 1'b0, 5, 8'h00);
    drain();
    for (int r = 0; r < N; r++) gen(r, 25);
    drain();
    bubbles = 1'b0;
    put(0, 1'b1, 10, 8'h5A);
    put(1, 1'b0, 7, 8'h00);
    rd_seen = 1'b0;
    n = 0;
    while (!rd_seen && n < 200) begin
      step();
      n++;
    end
    chk("inflight_read", 64'(rd_seen), 64'd1);
    mon_en = 1'b0;
    #1 rstn_i = 1'b0;
    #1;
    chk("arst_gnt", gnt_o, 64'd0);
    chk("arst_rvalid", rvalid_o, 64'd0);
    chk("arst_ram_en", 64'(ram_en_o), 64'd0);
    req_i = '0;
    op_q.delete(); rd_q.delete();
    for (int i = 0; i < N; i++) begin
      pend[i].delete();
      m_perf[i] = 0;
    end
    m_gnt = '0; m_ptr = 0; m_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_no_rvalid", rvalid_o, 64'd0);
      chk("rst_hold_gnt", gnt_o, 64'd0);
    end
`ifdef RAM_ARB_PERF_EN
    chk("perf_rst", perf_gnt_cnt_o, 64'd0);
`endif
    @(negedge clk);
    rstn_i = 1'b1;
    mon_en = 1'b1;
    put(0, 1'b1, 3, 8'h11);
    put(1, 1'b1, 4, 8'h22);
    drain();
    bubbles = 1'b1;
    for (int r = 0; r < N; r++) gen(r, 15);
    drain();
`ifdef RAM_ARB_PERF_EN
    for (int i = 0; i < N; i++) chk("perf_cnt", perf_gnt_cnt_o[i*16 +: 16], 64'(m_perf[i]));
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous RAM (1-cycle read latency; e.g. 76800 x 8) between NREQ requesters.
- Typical requesters: UART-RX loader, processing core, UART-TX dumper.
- Grants are burst-locked; read data is routed back with a per-requester valid strobe.
- Sits between requester FSMs and the ram instance in the top level.

Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 17, RAM address width
- DW, 8, RAM data width
- MAX_BURST, 16, maximum accesses per grant before forced rotation (1..255)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous, active-low reset
- req_i  in  NREQ  access request per requester, level
- we_i  in  NREQ  1=write, 0=read, per requester
- last_i  in  NREQ  marks final access of a burst
- addr_i  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW]
- wdata_i  in  NREQ*DW  flattened write data
- gnt_o  out  NREQ  one-hot grant, registered
- rvalid_o  out  NREQ  read data valid for requester i
- rdata_o  out  DW  read data, broadcast to all requesters
- ram_en_o  out  1  RAM enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  AW  RAM address
- ram_wdata_o  out  DW  RAM write data
- ram_rdata_i  in  DW  RAM read data, valid 1 cycle after a read enable

Behaviour:
- Reset (asynchronous, immediate):
  - gnt_o=0, rvalid_o=0, priority pointer=0, burst count=0, state=IDLE.
  - ram_en_o/ram_we_o/ram_addr_o/ram_wdata_o=0, because they are derived from the grant.
- States:
  - IDLE: gnt_o=0. If any req_i is high, pick the first requester with req_i high, searching from the pointer upward with wrap; grant it next cycle and go to OWN.
  - OWN: gnt_o holds one bit. An access is accepted in any cycle with gnt_o[g] & req_i[g].
    - ram_en_o = gnt_o[g] & req_i[g], combinational.
    - ram_we_o = we_i[g]; ram_addr_o/ram_wdata_o = slice g of addr_i/wdata_i.
    - All RAM outputs are 0 when no access is accepted.
  - Release happens on an accepted access with last_i[g]=1, on the MAX_BURST-th accepted access, or on any cycle with req_i[g]=0 while granted.
    - On release: pointer <= g+1 (mod NREQ), burst count <= 0, gnt_o <= 0 next cycle, state <= IDLE.
    - This forces at least one gap cycle between owners.
- Burst count:
  - Increments per accepted access.
  - Width is ceil(log2(MAX_BURST+1)) bits.
  - Never wraps, because it is cleared at release.
- Read return: a read accepted in cycle t gives rvalid_o[g]=1 and rdata_o=ram_rdata_i in cycle t+1.
  - This holds even if the grant has already dropped or passed to another requester.
  - rvalid_o is registered, one-hot, and asserted for one cycle per read.
- Arbitration latency: a request into an idle arbiter gets gnt_o one cycle later. The earliest access is in that cycle.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,0,...
  - No requester waits more than (NREQ-1)*(MAX_BURST+1) cycles after the arbiter enters IDLE.
- Requester changes of we_i/addr_i mid-burst are legal, one access per cycle.
- Reset mid-burst: the in-flight read never produces rvalid_o; the pointer returns to 0.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- Defined:
  - Adds output perf_gnt_cnt_o, width NREQ*16: per-requester count of accepted accesses.
  - Counters are 16-bit and saturate at 0xFFFF.
  - Cleared by reset only.
- Not defined: the port and its counters are absent; all other behaviour is identical.

Decomposition:
- Shared package ram_arb_pkg:
  - State encoding constants (IDLE, OWN).
  - Defaults for AW=17, DW=8, RAM depth 76800.
  - Function for burst-counter width.
- Natural sub-module: rr_pick.
  - Combinational round-robin one-hot selector.
  - Inputs: req vector and pointer. Output: one-hot winner.

Test Plan:
- Single read: reset, req_i=001, we_i=0, addr 0x00005, RAM preloaded 0xA5 at 5 -> gnt_o=001 at cycle+1, ram_en_o=1 with ram_addr_o=5, rvalid_o=001 and rdata_o=0xA5 on the following cycle.
- Burst write with last: requester 1 writes 0x10..0x13 to addresses 0..3, last_i on the 4th -> four accepted writes on consecutive cycles, gnt_o=000 the next cycle, pointer=2.
- Forced rotation: requester 0 holds req high with no last_i, other requesters idle -> exactly 16 accesses, one gap cycle, then gnt_o=001 again.
- Contention fairness: req_i=111, each requester issues 2-access bursts with last_i -> grant order 0,1,2,0 with a one-cycle gap between owners.
- Read on last access: requester 2 reads address 7 (0x3C) with last_i while requester 0 is waiting -> rvalid_o=100 with 0x3C in the same cycle gnt_o becomes 000; gnt_o=001 one cycle later.
- Async reset mid-burst: assert rstn_i=0 while a read is in flight -> gnt_o, rvalid_o and ram_en_o drop to 0 immediately, no rvalid_o after release; with RAM_ARB_PERF_EN, counters read 0.
